// File: rtl/spi_slave_rx_if.sv
// Pin and handshake bundle between the SPI master / AES core side and spi_slave_rx.
// The slave modport is the receiver's view; the master modport drives the link and consumes frames.
interface spi_slave_rx_if #(
    parameter int DATA_BYTES = 16
);
    logic                    sclk;
    logic                    cs_n;
    logic                    mosi;
    logic                    miso;
    logic [127:0]            tx_data;
    logic                    tx_valid;
    logic [1:0]              key_size;
    logic [255:0]            key;
    logic [8*DATA_BYTES-1:0] data;
    logic                    frame_valid;
    logic                    frame_ready;
    logic                    err;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid, frame_ready,
        output miso, key_size, key, data, frame_valid, err
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid, frame_ready,
        input  miso, key_size, key, data, frame_valid, err
    );
endinterface

// File: rtl/spi_slave_rx.sv
// Mode-0 SPI slave: oversamples the link, deserializes header/key/data into a frame for the AES core,
// and shifts a 128-bit result word back on MISO.
module spi_slave_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BYTES  = 16
) (
    input logic           clk,
    input logic           reset,
    spi_slave_rx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HDR, KEY, DATA, DONE, ERR} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0]  sclkSync_q, csSync_q, mosiSync_q;
    logic                    sclkPrev_q, csPrev_q;
    logic                    sclkS, csS, mosiS;
    logic                    sclkRise, sclkFall, csRise, csFall;

    logic [2:0]              bitCnt_q;
    logic [5:0]              byteCnt_q;
    logic [6:0]              shiftByte_q;
    logic [1:0]              keySizeWork_q, keySize_q;
    logic [255:0]            keyWork_q, key_q;
    logic [8*DATA_BYTES-9:0] dataWork_q;
    logic [8*DATA_BYTES-1:0] data_q;
    logic [127:0]            txShift_q;
    logic                    frameValid_q, err_q;

    logic [7:0]              rxByte;
    logic [7:0]              keyIdx;
    logic [5:0]              keyBytes;
    logic                    byteDone, lastKey, lastData;
    logic                    receiving, startFrame, sampleBit, shiftTx, frameDone, loadOut, errNow;

    // The cs_n chain resets low so a chip select already asserted at reset release never looks like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclkSync_q <= '0;
            csSync_q   <= '0;
            mosiSync_q <= '0;
            sclkPrev_q <= 1'b0;
            csPrev_q   <= 1'b0;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], bus.sclk};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], bus.cs_n};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], bus.mosi};
            sclkPrev_q <= sclkS;
            csPrev_q   <= csS;
        end
    end

    assign sclkS    = sclkSync_q[SYNC_STAGES-1];
    assign csS      = csSync_q[SYNC_STAGES-1];
    assign mosiS    = mosiSync_q[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~sclkPrev_q;
    assign sclkFall = ~sclkS & sclkPrev_q;
    assign csRise   = csS & ~csPrev_q;
    assign csFall   = ~csS & csPrev_q;

    assign rxByte   = {shiftByte_q, mosiS};
    assign byteDone = sclkRise && (bitCnt_q == 3'd7);
    assign keyIdx   = 8'd255 - {byteCnt_q[4:0], 3'b000};
    assign lastKey  = (byteCnt_q == keyBytes - 6'd1);
    assign lastData = (byteCnt_q == 6'(DATA_BYTES - 1));

    always_comb begin
        case (keySizeWork_q)
            2'b00:   keyBytes = 6'd16;
            2'b01:   keyBytes = 6'd24;
            default: keyBytes = 6'd32;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // In DATA the final sampling edge outranks a simultaneous cs_n rise; DONE/ERR leave on the cs_n level for that reason.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (csFall) state_d = HDR;
            HDR: begin
                if (csRise)        state_d = IDLE;
                else if (byteDone) state_d = (rxByte[1:0] == 2'b11) ? ERR : KEY;
            end
            KEY: begin
                if (csRise)                   state_d = IDLE;
                else if (byteDone && lastKey) state_d = DATA;
            end
            DATA: begin
                if (frameDone)   state_d = DONE;
                else if (csRise) state_d = IDLE;
            end
            DONE:    if (csS) state_d = IDLE;
            ERR:     if (csS) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        receiving  = (state_q == HDR) || (state_q == KEY) || (state_q == DATA);
        startFrame = (state_q == IDLE) && csFall;
        sampleBit  = receiving && sclkRise;
        shiftTx    = receiving && sclkFall;
        frameDone  = (state_q == DATA) && byteDone && lastData;
        loadOut    = frameDone && (!frameValid_q || bus.frame_ready);
        errNow     = (receiving && csRise && !frameDone)
                   || ((state_q == HDR) && byteDone && (rxByte[1:0] == 2'b11))
                   || (frameDone && !loadOut);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitCnt_q      <= '0;
            byteCnt_q     <= '0;
            shiftByte_q   <= '0;
            keySizeWork_q <= '0;
            keyWork_q     <= '0;
            dataWork_q    <= '0;
            txShift_q     <= '0;
        end else if (startFrame) begin
            bitCnt_q    <= '0;
            byteCnt_q   <= '0;
            shiftByte_q <= '0;
            keyWork_q   <= '0;
            txShift_q   <= bus.tx_valid ? bus.tx_data : '0;
        end else begin
            if (sampleBit) begin
                shiftByte_q <= rxByte[6:0];
                bitCnt_q    <= bitCnt_q + 3'd1;
            end
            if (sampleBit && byteDone) begin
                case (state_q)
                    HDR: begin
                        keySizeWork_q <= rxByte[1:0];
                        byteCnt_q     <= '0;
                    end
                    KEY: begin
                        keyWork_q[keyIdx -: 8] <= rxByte;
                        byteCnt_q              <= lastKey ? 6'd0 : byteCnt_q + 6'd1;
                    end
                    DATA: begin
                        dataWork_q <= {dataWork_q[8*DATA_BYTES-17:0], rxByte};
                        byteCnt_q  <= byteCnt_q + 6'd1;
                    end
                    default: ;
                endcase
            end
            if (shiftTx) txShift_q <= {txShift_q[126:0], 1'b0};
        end
    end

    // Shadow copies seen by the AES core; only a complete, non-overrun frame replaces them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q        <= '0;
            keySize_q    <= '0;
            data_q       <= '0;
            frameValid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (loadOut) begin
                key_q     <= keyWork_q;
                keySize_q <= keySizeWork_q;
                data_q    <= {dataWork_q, rxByte};
            end
            if (loadOut)                            frameValid_q <= 1'b1;
            else if (frameValid_q && bus.frame_ready) frameValid_q <= 1'b0;
            err_q <= errNow;
        end
    end

    assign bus.miso        = txShift_q[127];
    assign bus.key         = key_q;
    assign bus.key_size    = keySize_q;
    assign bus.data        = data_q;
    assign bus.frame_valid = frameValid_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a table of whole frames plus hand-written overrun, abort,
// MISO, simultaneous cs_n/final-edge and reset-mid-frame sequences.
module tb_spi_slave_rx;
    localparam int DATA_BYTES = 16;
    localparam logic [127:0] DATA_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] DATA_B  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] TX_WORD = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_128 = 256'h000102030405060708090a0b0c0d0e0f00000000000000000000000000000000;
    localparam logic [255:0] KEY_192 = 256'h000102030405060708090a0b0c0d0e0f10111213141516170000000000000000;
    localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    typedef struct {
        logic [7:0]   header;
        int           keyBytes;
        int           dataBytes;
        logic [127:0] dataIn;
        int           expErrCycles;
        int           expValidCycles;
        logic [1:0]   expKeySize;
        logic [255:0] expKey;
        logic [127:0] expData;
    } vector_t;

    logic clk = 1'b0;
    logic reset;
    int checkCount, passCount, failCount;
    int errCount, validCycles;
    int misoCnt;
    logic [511:0] misoCap;
    vector_t vectors[5];

    spi_slave_rx_if #(.DATA_BYTES(DATA_BYTES)) bus ();

    spi_slave_rx #(.SYNC_STAGES(2), .DATA_BYTES(DATA_BYTES)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.err) errCount++;
        if (bus.frame_valid) validCycles++;
    end

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic clearCounters();
        errCount    = 0;
        validCycles = 0;
    endtask

    task automatic sendByte(input logic [7:0] b, input bit csWithLast);
        for (int i = 7; i >= 0; i--) begin
            bus.mosi = b[i];
            waitClk(4);
            if (misoCnt < 512) misoCap[511 - misoCnt] = bus.miso;
            misoCnt++;
            bus.sclk = 1'b1;
            if (csWithLast && i == 0) bus.cs_n = 1'b1;
            waitClk(4);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic beginFrame();
        misoCnt = 0;
        misoCap = '0;
        bus.cs_n = 1'b0;
        waitClk(6);
    endtask

    task automatic endFrame();
        waitClk(4);
        bus.cs_n = 1'b1;
        waitClk(10);
    endtask

    task automatic sendBody(input logic [7:0] header, input int keyBytes, input int dataBytes,
                            input logic [127:0] dataIn, input bit csWithLast);
        logic [127:0] d;
        int total;
        d = dataIn;
        total = 1 + keyBytes + dataBytes;
        sendByte(header, csWithLast && total == 1);
        for (int i = 0; i < keyBytes; i++) sendByte(8'(i), csWithLast && (i + 2) == total);
        for (int i = 0; i < dataBytes; i++) begin
            sendByte(d[127:120], csWithLast && (2 + keyBytes + i) == total);
            d = d << 8;
        end
    endtask

    task automatic applyStimulus(input vector_t v);
        clearCounters();
        beginFrame();
        sendBody(v.header, v.keyBytes, v.dataBytes, v.dataIn, 1'b0);
        endFrame();
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        clearCounters();
        misoCnt = 0;
        misoCap = '0;
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        bus.tx_data = '0;
        bus.tx_valid = 1'b0;
        bus.frame_ready = 1'b1;
        reset = 1'b1;

        vectors[0] = '{header: 8'h00, keyBytes: 16, dataBytes: 16, dataIn: DATA_A, expErrCycles: 0,
                       expValidCycles: 1, expKeySize: 2'b00, expKey: KEY_128, expData: DATA_A};
        vectors[1] = '{header: 8'hfd, keyBytes: 24, dataBytes: 16, dataIn: DATA_B, expErrCycles: 0,
                       expValidCycles: 1, expKeySize: 2'b01, expKey: KEY_192, expData: DATA_B};
        vectors[2] = '{header: 8'h02, keyBytes: 32, dataBytes: 16, dataIn: DATA_A, expErrCycles: 0,
                       expValidCycles: 1, expKeySize: 2'b10, expKey: KEY_256, expData: DATA_A};
        vectors[3] = '{header: 8'h03, keyBytes: 0, dataBytes: 0, dataIn: DATA_A, expErrCycles: 1,
                       expValidCycles: 0, expKeySize: 2'b00, expKey: '0, expData: '0};
        vectors[4] = '{header: 8'h00, keyBytes: 16, dataBytes: 16, dataIn: DATA_B, expErrCycles: 0,
                       expValidCycles: 1, expKeySize: 2'b00, expKey: KEY_128, expData: DATA_B};

        waitClk(3);
        checkOutput("reset miso", bus.miso, 0);
        checkOutput("reset key_size", bus.key_size, 0);
        checkOutput("reset key", bus.key, 0);
        checkOutput("reset data", bus.data, 0);
        checkOutput("reset frame_valid", bus.frame_valid, 0);
        checkOutput("reset err", bus.err, 0);
        reset = 1'b0;
        waitClk(5);

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vectors[v]);
            checkOutput($sformatf("vec%0d err cycles", v), errCount, vectors[v].expErrCycles);
            checkOutput($sformatf("vec%0d valid cycles", v), validCycles, vectors[v].expValidCycles);
            if (vectors[v].expValidCycles != 0) begin
                checkOutput($sformatf("vec%0d key_size", v), bus.key_size, vectors[v].expKeySize);
                checkOutput($sformatf("vec%0d key", v), bus.key, vectors[v].expKey);
                checkOutput($sformatf("vec%0d data", v), bus.data, vectors[v].expData);
            end
        end

        // AES-256 frame held unaccepted, then released
        bus.frame_ready = 1'b0;
        clearCounters();
        beginFrame();
        sendBody(8'h02, 32, DATA_BYTES, DATA_B, 1'b0);
        endFrame();
        checkOutput("hold valid early", bus.frame_valid, 1);
        waitClk(20);
        checkOutput("hold valid late", bus.frame_valid, 1);
        checkOutput("hold key", bus.key, KEY_256);
        checkOutput("hold key_size", bus.key_size, 2'b10);
        checkOutput("hold data", bus.data, DATA_B);
        checkOutput("hold err cycles", errCount, 0);
        bus.frame_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("valid clears after ready", bus.frame_valid, 0);
        waitClk(4);

        // Overrun: second frame completes while the first is pending
        bus.frame_ready = 1'b0;
        clearCounters();
        beginFrame();
        sendBody(8'h00, 16, DATA_BYTES, DATA_A, 1'b0);
        endFrame();
        beginFrame();
        sendBody(8'h01, 24, DATA_BYTES, DATA_B, 1'b0);
        endFrame();
        checkOutput("overrun err cycles", errCount, 1);
        checkOutput("overrun valid", bus.frame_valid, 1);
        checkOutput("overrun key", bus.key, KEY_128);
        checkOutput("overrun key_size", bus.key_size, 2'b00);
        checkOutput("overrun data", bus.data, DATA_A);
        bus.frame_ready = 1'b1;
        waitClk(3);
        checkOutput("overrun accepted", bus.frame_valid, 0);

        // Abort after five key bytes, then a full frame
        clearCounters();
        beginFrame();
        sendByte(8'h00, 1'b0);
        for (int i = 0; i < 5; i++) sendByte(8'(i), 1'b0);
        endFrame();
        checkOutput("abort err cycles", errCount, 1);
        checkOutput("abort valid cycles", validCycles, 0);
        clearCounters();
        beginFrame();
        sendBody(8'h00, 16, DATA_BYTES, DATA_B, 1'b0);
        endFrame();
        checkOutput("post-abort valid cycles", validCycles, 1);
        checkOutput("post-abort key", bus.key, KEY_128);
        checkOutput("post-abort data", bus.data, DATA_B);

        // Result word on MISO, zeros once it is exhausted
        bus.tx_valid = 1'b1;
        bus.tx_data  = TX_WORD;
        beginFrame();
        sendBody(8'h00, 16, DATA_BYTES, DATA_A, 1'b0);
        endFrame();
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        checkOutput("miso first 128 bits", misoCap[511:384], TX_WORD);
        checkOutput("miso after 128 bits", misoCap[383:248], 0);

        // cs_n rises in the same synchronized cycle as the last sampling edge
        clearCounters();
        beginFrame();
        sendBody(8'h02, 32, DATA_BYTES, DATA_B, 1'b1);
        waitClk(12);
        checkOutput("simul valid cycles", validCycles, 1);
        checkOutput("simul err cycles", errCount, 0);
        checkOutput("simul key", bus.key, KEY_256);
        checkOutput("simul data", bus.data, DATA_B);

        // Reset mid-frame, with cs_n still low at release
        beginFrame();
        sendByte(8'h00, 1'b0);
        sendByte(8'h00, 1'b0);
        sendByte(8'h01, 1'b0);
        waitClk(1);
        reset = 1'b1;
        #1;
        checkOutput("midreset key", bus.key, 0);
        checkOutput("midreset key_size", bus.key_size, 0);
        checkOutput("midreset data", bus.data, 0);
        checkOutput("midreset frame_valid", bus.frame_valid, 0);
        checkOutput("midreset err", bus.err, 0);
        checkOutput("midreset miso", bus.miso, 0);
        waitClk(3);
        reset = 1'b0;
        waitClk(6);
        clearCounters();
        sendBody(8'h00, 16, DATA_BYTES, DATA_A, 1'b0);
        endFrame();
        checkOutput("stale cs valid cycles", validCycles, 0);
        checkOutput("stale cs err cycles", errCount, 0);
        checkOutput("stale cs key", bus.key, 0);
        applyStimulus(vectors[0]);
        checkOutput("after reset valid cycles", validCycles, 1);
        checkOutput("after reset key", bus.key, KEY_128);
        checkOutput("after reset data", bus.data, DATA_A);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
